// File: rtl/axi_master_ctrl.sv
// AXI4 initiator: turns one cmd into one AXI4 burst; one transaction in flight; stream-side write/read data.
// Latency: cmd accept -> AW/ARVALID 1 cycle; last B/R handshake -> resp_valid 1 cycle.
// Backpressure: wr/rd streams are combinationally tied to W/R ready; optional watchdog via AXI_MASTER_TIMEOUT_EN.
module axi_master_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int ID_WIDTH       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ID_WIDTH-1:0]   cmd_id,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic [1:0]            cmd_burst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ID_WIDTH-1:0]   rd_id,
    output logic                  rd_last,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_WIDTH-1:0]   resp_id,
    output logic                  resp_write,
    output logic [1:0]            resp_code,
    output logic                  err_timeout,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_RESP} state_t;

    localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [1:0]            resp_code_q, resp_code_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  write_q, write_d;
    logic [7:0]            cnt_q, cnt_d;

    logic                  beat_last;
    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [1:0]            beat_code;
    logic                  unused_bid;

    // bid is irrelevant with a single outstanding transaction
    assign unused_bid = ^m_axi_bid;

    assign beat_last    = (cnt_q == len_q);
    assign m_axi_wvalid = wr_valid && (state_q == S_W);
    assign wr_ready     = m_axi_wready && (state_q == S_W);
    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = wr_strb;
    assign m_axi_wlast  = beat_last;
    assign m_axi_rready = rd_ready && (state_q == S_R);
    assign rd_valid     = m_axi_rvalid && (state_q == S_R);
    assign rd_data      = m_axi_rdata;
    assign rd_id        = m_axi_rid;
    assign rd_last      = beat_last;

    assign aw_hs = awvalid_q && m_axi_awready;
    assign ar_hs = arvalid_q && m_axi_arready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign b_hs  = bready_q && m_axi_bvalid;
    assign r_hs  = m_axi_rvalid && m_axi_rready;

    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        awvalid_d    = awvalid_q;
        arvalid_d    = arvalid_q;
        bready_d     = bready_q;
        resp_valid_d = resp_valid_q;
        resp_code_d  = resp_code_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        burst_d      = burst_q;
        id_d         = id_q;
        write_d      = write_q;
        cnt_d        = cnt_q;
        beat_code    = m_axi_rresp;
        // a misplaced rlast is reported as at least SLVERR
        if ((m_axi_rlast != beat_last) && (beat_code < 2'b10)) beat_code = 2'b10;
        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    len_d       = cmd_len;
                    size_d      = (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
                    burst_d     = cmd_burst;
                    id_d        = cmd_id;
                    write_d     = cmd_write;
                    cnt_d       = 8'd0;
                    resp_code_d = 2'b00;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        state_d   = S_AW;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_AR;
                    end
                end
            end
            S_AW: if (aw_hs) begin
                awvalid_d = 1'b0;
                state_d   = S_W;
            end
            S_W: if (w_hs) begin
                cnt_d = cnt_q + 8'd1;
                if (beat_last) begin
                    bready_d = 1'b1;
                    state_d  = S_B;
                end
            end
            S_B: if (b_hs) begin
                bready_d     = 1'b0;
                resp_code_d  = m_axi_bresp;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_AR: if (ar_hs) begin
                arvalid_d = 1'b0;
                state_d   = S_R;
            end
            S_R: if (r_hs) begin
                cnt_d = cnt_q + 8'd1;
                if (beat_code > resp_code_q) resp_code_d = beat_code;
                if (beat_last) begin
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end
            end
            S_RESP: if (resp_ready) begin
                resp_valid_d = 1'b0;
                cmd_ready_d  = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_code_q  <= 2'b00;
            addr_q       <= '0;
            len_q        <= 8'd0;
            size_q       <= 3'd0;
            burst_q      <= 2'b00;
            id_q         <= '0;
            write_q      <= 1'b0;
            cnt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            awvalid_q    <= awvalid_d;
            arvalid_q    <= arvalid_d;
            bready_q     <= bready_d;
            resp_valid_q <= resp_valid_d;
            resp_code_q  <= resp_code_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            burst_q      <= burst_d;
            id_q         <= id_d;
            write_q      <= write_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_bready  = bready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_code     = resp_code_q;
    assign resp_id       = id_q;
    assign resp_write    = write_q;
    assign m_axi_awid    = id_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = size_q;
    assign m_axi_awburst = burst_q;
    assign m_axi_arid    = id_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = size_q;
    assign m_axi_arburst = burst_q;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arprot  = 3'b000;

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;
    logic            waiting;

    assign waiting = (state_q == S_AW) || (state_q == S_W) || (state_q == S_B) ||
                     (state_q == S_AR) || (state_q == S_R);

    // Flags a stall only; the FSM keeps waiting for the responder
    always_comb begin
        wd_d  = wd_q;
        err_d = err_q;
        if (!waiting || aw_hs || w_hs || b_hs || ar_hs || r_hs || (state_d != state_q)) begin
            wd_d = '0;
        end else if (wd_q == WD_LIM) begin
            err_d = 1'b1;
        end else begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err_timeout = err_q;
`else
    // No watchdog in this build: the flag is a constant low
    assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_axi_master_ctrl.sv
// Directed bench for axi_master_ctrl with a bench-side memory model and expectation queues.
module tb_axi_master_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_id, cmd_len;
    logic [15:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [1:0]  cmd_burst;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic [7:0]  rd_id;
    logic        resp_valid, resp_ready, resp_write, err_timeout;
    logic [7:0]  resp_id;
    logic [1:0]  resp_code;
    logic [7:0]  m_axi_awid, m_axi_awlen, m_axi_arid, m_axi_arlen, m_axi_bid, m_axi_rid;
    logic [15:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awsize, m_axi_arsize, m_axi_awprot, m_axi_arprot;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awlock, m_axi_arlock;
    logic [3:0]  m_axi_awcache, m_axi_arcache, m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axi_master_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .STRB_WIDTH(4), .ID_WIDTH(8),
                      .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_id(rd_id), .rd_last(rd_last),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_write(resp_write), .resp_code(resp_code), .err_timeout(err_timeout),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int          checks = 0;
    int          failures = 0;
    logic [31:0] mem [0:255];
    logic [31:0] exp_w [$];
    logic [31:0] exp_rd [$];
    logic [10:0] exp_resp [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic wr, input logic [7:0] id, input logic [15:0] addr,
                         input logic [7:0] len, input logic [2:0] size, input logic [1:0] code);
        int n;
        n = 0;
        exp_resp.push_back({id, wr, code});
        if (!wr) for (int i = 0; i <= int'(len); i++) exp_rd.push_back(mem[(int'(addr[9:2]) + i) % 256]);
        cmd_valid = 1'b1; cmd_write = wr; cmd_id = id; cmd_addr = addr;
        cmd_len = len; cmd_size = size; cmd_burst = 2'b01;
        while (!cmd_ready && n < 50) begin step; n++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        step;
        cmd_valid = 1'b0;
        chk("awvalid_latency", m_axi_awvalid, wr);
        chk("arvalid_latency", m_axi_arvalid, !wr);
        chk("cmd_ready_drop", cmd_ready, 0);
    endtask

    task automatic addr_phase(input logic wr, input int delay, input logic [15:0] addr,
                              input logic [7:0] len, input logic [2:0] size, input logic [7:0] id);
        int stable;
        stable = 1;
        for (int i = 0; i < delay; i++) begin
            if (!((wr ? m_axi_awvalid : m_axi_arvalid) === 1'b1 &&
                  (wr ? m_axi_awaddr : m_axi_araddr) === addr)) stable = 0;
            step;
        end
        chk("addr_stable", stable, 1);
        chk("axaddr", wr ? m_axi_awaddr : m_axi_araddr, addr);
        chk("axlen", wr ? m_axi_awlen : m_axi_arlen, len);
        chk("axsize", wr ? m_axi_awsize : m_axi_arsize, size);
        chk("axburst", wr ? m_axi_awburst : m_axi_arburst, 2'b01);
        chk("axid", wr ? m_axi_awid : m_axi_arid, id);
        chk("axattr", {m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_arlock, m_axi_arcache, m_axi_arprot},
            {1'b0, 4'b0011, 3'b000, 1'b0, 4'b0011, 3'b000});
        if (wr) m_axi_awready = 1'b1; else m_axi_arready = 1'b1;
        step;
        m_axi_awready = 1'b0; m_axi_arready = 1'b0;
        chk("axvalid_clear", wr ? m_axi_awvalid : m_axi_arvalid, 0);
    endtask

    task automatic w_phase(input logic [7:0] len, input logic [15:0] addr, input logic [31:0] base, input int pat);
        int beat, n;
        beat = 0; n = 0;
        for (int i = 0; i <= int'(len); i++) exp_w.push_back(base + 32'h11 * (i + 1));
        while (beat <= int'(len) && n < 100) begin
            wr_valid = 1'b1; wr_data = base + 32'h11 * (beat + 1); wr_strb = 4'hF;
            m_axi_wready = (pat != 0) ? n[0] : 1'b1;
            #1;
            if (m_axi_wvalid && m_axi_wready) begin
                chk("wr_ready", wr_ready, 1);
                chk("wdata", m_axi_wdata, exp_w.pop_front());
                chk("wstrb", m_axi_wstrb, 4'hF);
                chk("wlast", m_axi_wlast, beat == int'(len));
                mem[(int'(addr[9:2]) + beat) % 256] = base + 32'h11 * (beat + 1);
                beat++;
            end
            step;
            n++;
        end
        wr_valid = 1'b0; m_axi_wready = 1'b0;
        chk("w_beat_count", beat, int'(len) + 1);
    endtask

    task automatic b_phase(input int delay, input logic [1:0] bresp, input logic [7:0] bid);
        int n;
        n = 0;
        repeat (delay) step;
        m_axi_bvalid = 1'b1; m_axi_bresp = bresp; m_axi_bid = bid;
        while (!m_axi_bready && n < 50) begin step; n++; end
        chk("bready", m_axi_bready, 1);
        step;
        m_axi_bvalid = 1'b0;
        chk("b_to_resp_latency", resp_valid, 1);
    endtask

    task automatic r_phase(input logic [7:0] len, input logic [7:0] rid, input int err_beat,
                           input int early_last, input int pat);
        int beat, n;
        beat = 0; n = 0;
        while (beat <= int'(len) && n < 100) begin
            m_axi_rvalid = 1'b1; m_axi_rid = rid;
            m_axi_rdata = 32'hDEAD_0000 + beat;
            if (exp_rd.size() > 0) m_axi_rdata = exp_rd[0];
            m_axi_rresp = (beat == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast = (beat == int'(len)) || (beat == early_last);
            rd_ready = (pat != 0) ? ~n[0] : 1'b1;
            #1;
            chk("rready_mirror", m_axi_rready, rd_ready);
            if (rd_valid && rd_ready) begin
                chk("rd_data", rd_data, exp_rd.pop_front());
                chk("rd_last", rd_last, beat == int'(len));
                chk("rd_id", rd_id, rid);
                beat++;
            end
            step;
            n++;
        end
        #1;
        chk("rd_valid_after_last", rd_valid, 0);
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; rd_ready = 1'b0;
        chk("r_beat_count", beat, int'(len) + 1);
        chk("r_to_resp_latency", resp_valid, 1);
    endtask

    task automatic resp_phase(input int delay);
        logic [10:0] e;
        repeat (delay) begin
            chk("resp_hold", resp_valid, 1);
            step;
        end
        resp_ready = 1'b1;
        e = exp_resp.pop_front();
        chk("resp_valid", resp_valid, 1);
        chk("resp_id", resp_id, e[10:3]);
        chk("resp_write", resp_write, e[2]);
        chk("resp_code", resp_code, e[1:0]);
        step;
        resp_ready = 1'b0;
        chk("resp_valid_clear", resp_valid, 0);
        chk("cmd_ready_return", cmd_ready, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        cmd_valid = 0; cmd_write = 0; cmd_id = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0; cmd_burst = 0;
        wr_valid = 0; wr_data = 0; wr_strb = 0; rd_ready = 0; resp_ready = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bid = 0; m_axi_bresp = 0; m_axi_bvalid = 0;
        m_axi_arready = 0; m_axi_rid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0; m_axi_rvalid = 0;

        // Reset state
        repeat (3) step;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_valids", {m_axi_awvalid, m_axi_arvalid, m_axi_bready, resp_valid, err_timeout}, 5'b0);
        @(negedge clk); rst_n = 1'b1;
        step;
        chk("cmd_ready_after_rst", cmd_ready, 1);

        // Write 4 beats of 11,22,33,44
        issue(1, 8'h01, 16'h0010, 8'd3, 3'd2, 2'b00);
        addr_phase(1, 0, 16'h0010, 8'd3, 3'd2, 8'h01);
        w_phase(8'd3, 16'h0010, 32'h0, 0);
        b_phase(2, 2'b00, 8'h01);
        resp_phase(0);

        // Read back; oversized cmd_size clamps to 2
        issue(0, 8'h02, 16'h0010, 8'd3, 3'd5, 2'b00);
        addr_phase(0, 0, 16'h0010, 8'd3, 3'd2, 8'h02);
        r_phase(8'd3, 8'h02, -1, -1, 0);
        resp_phase(2);

        // AW stall, W ready toggling, then read with rd_ready toggling
        issue(1, 8'h03, 16'h0020, 8'd1, 3'd2, 2'b00);
        addr_phase(1, 5, 16'h0020, 8'd1, 3'd2, 8'h03);
        w_phase(8'd1, 16'h0020, 32'h100, 1);
        b_phase(0, 2'b00, 8'h03);
        resp_phase(0);
        issue(0, 8'h04, 16'h0020, 8'd1, 3'd2, 2'b00);
        addr_phase(0, 3, 16'h0020, 8'd1, 3'd2, 8'h04);
        r_phase(8'd1, 8'h04, -1, -1, 1);
        resp_phase(1);

        // SLVERR on beat 1, then early rlast
        issue(0, 8'h05, 16'h0010, 8'd3, 3'd2, 2'b10);
        addr_phase(0, 0, 16'h0010, 8'd3, 3'd2, 8'h05);
        r_phase(8'd3, 8'h05, 1, -1, 0);
        resp_phase(0);
        issue(0, 8'h06, 16'h0010, 8'd3, 3'd2, 2'b10);
        addr_phase(0, 0, 16'h0010, 8'd3, 3'd2, 8'h06);
        r_phase(8'd3, 8'h06, -1, 1, 0);
        resp_phase(0);

        // len=0 write, bresp error, foreign bid
        issue(1, 8'h07, 16'h0030, 8'd0, 3'd2, 2'b10);
        addr_phase(1, 0, 16'h0030, 8'd0, 3'd2, 8'h07);
        w_phase(8'd0, 16'h0030, 32'h200, 0);
        b_phase(1, 2'b10, 8'hEE);
        resp_phase(0);

        // Asynchronous reset in the middle of the W burst
        issue(1, 8'h55, 16'h0040, 8'd3, 3'd2, 2'b00);
        addr_phase(1, 0, 16'h0040, 8'd3, 3'd2, 8'h55);
        wr_valid = 1'b1; wr_strb = 4'hF; m_axi_wready = 1'b1; wr_data = 32'h1;
        step; wr_data = 32'h2;
        step; wr_data = 32'h3;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valids", {m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, m_axi_bready, resp_valid, cmd_ready},
            6'b0);
        exp_resp.delete();
        wr_valid = 1'b0; m_axi_wready = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("cmd_ready_before_edge", cmd_ready, 0);
        step;
        chk("cmd_ready_one_edge", cmd_ready, 1);
        issue(0, 8'h08, 16'h0010, 8'd1, 3'd2, 2'b00);
        addr_phase(0, 0, 16'h0010, 8'd1, 3'd2, 8'h08);
        r_phase(8'd1, 8'h08, -1, -1, 0);
        resp_phase(0);

        // Withheld bvalid: watchdog
        issue(1, 8'h09, 16'h0080, 8'd0, 3'd2, 2'b00);
        addr_phase(1, 0, 16'h0080, 8'd0, 3'd2, 8'h09);
        w_phase(8'd0, 16'h0080, 32'h300, 0);
`ifdef AXI_MASTER_TIMEOUT_EN
        repeat (15) step;
        chk("err_timeout_early", err_timeout, 0);
        step;
        chk("err_timeout_set", err_timeout, 1);
        repeat (4) step;
        chk("err_timeout_sticky", err_timeout, 1);
`else
        repeat (40) step;
        chk("err_timeout_off", err_timeout, 0);
`endif
        chk("b_still_waiting", m_axi_bready, 1);
        b_phase(0, 2'b00, 8'h09);
        resp_phase(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
